util_tx_timestamp_inserter: RTL
===============================

// Module: util_tx_timestamp_inserter
// PURPOSE
//  DMA-clock stage directly upstream of util_upack2_timestamp. Takes a plain TX DMA stream whose first block per
//  transfer carries a 64-bit start timestamp. Re-emits the stream with one timestamp block before every run of
//  timestamp_every data blocks, the framing util_upack2_timestamp expects. Host software writes one timestamp per
//  buffer instead of interleaving one per period.
// PARAMETERS
//  NUM_OF_CHANNELS      4   channels per block
//  SAMPLES_PER_CHANNEL  1   samples per channel per block
//  SAMPLE_DATA_WIDTH    16  bits per sample; DW = product of the three, must be >= 64 (elaboration error otherwise)
// PORTS
//  dma_clk            in   1   single clock, DMA domain
//  dma_resetn         in   1   synchronous, active-low reset
//  timestamp_every    in   32  data blocks between timestamps; 0 = bypass; sampled on transfer start
//  samples_per_block  in   8   per-channel samples per block for current channel mask; sampled on transfer start
//  inserted_count     out  32  timestamp blocks emitted since reset (wraps)
//  s_axis_valid       in   1   DMA data valid
//  s_axis_ready       out  1   DMA data accept
//  s_axis_xfer_req    in   1   DMA transfer active
//  s_axis_data        in   DW  DMA data
//  m_axis_valid       out  1   to util_upack2_timestamp s_axis_valid
//  m_axis_ready       in   1   from util_upack2_timestamp s_axis_ready
//  m_axis_xfer_req    out  1   to util_upack2_timestamp s_axis_xfer_req
//  m_axis_data        out  DW  to util_upack2_timestamp s_axis_data; timestamp blocks carry the value in [63:0], zeros above
// BEHAVIOUR
//  Reset (dma_resetn=0 at posedge) values:
//  - m_axis_valid=0, m_axis_data=0, m_axis_xfer_req=0, inserted_count=0, FSM=IDLE.
//  - s_axis_ready=0 (combinational, low in IDLE).
//  Output register:
//  - single m_axis register.
//  - Loads when (!m_axis_valid || m_axis_ready).
//  - m_axis_data held stable while m_axis_valid && !m_axis_ready.
//  - Latency s->m is 1 cycle. Full throughput: one block per cycle while m_axis_ready=1.
//  - m_axis_xfer_req = s_axis_xfer_req delayed 1 cycle.
//  FSM states:
//  - IDLE: wait for s_axis_xfer_req=1.
//    - Latch every_q=timestamp_every.
//    - Latch step_q = timestamp_every * samples_per_block (64-bit, zero-extended).
//    - Go to BYPASS if timestamp_every==0, else go to HDR.
//  - HDR:
//    - s_axis_ready=1 (sink only).
//    - On s handshake: ts_q = s_axis_data[63:0], go to TS. Header block is never forwarded.
//  - TS:
//    - s_axis_ready=0.
//    - On output load: emit {0, ts_q}, ts_q <= ts_q + step_q (mod 2^64), cnt=0, inserted_count++, go to DATA.
//  - DATA:
//    - s_axis_ready = (!m_axis_valid || m_axis_ready).
//    - Each s handshake forwards s_axis_data unchanged and increments cnt.
//    - On handshake with cnt==every_q-1, go to TS. Exactly every_q data blocks per period.
//  - BYPASS:
//    - s_axis_ready = (!m_axis_valid || m_axis_ready).
//    - Pure passthrough. No header consumed.
//  Transfer end / abort:
//  - s_axis_xfer_req=0 in any state returns to IDLE next cycle.
//  - A partial period is not padded.
//  - An undelivered m_axis beat is dropped (m_axis_valid cleared). util_upack2_timestamp discards state on xfer_req fall.
//  - A new xfer_req rise in the same cycle that IDLE is entered is handled on the following cycle.
//  Configuration:
//  - timestamp_every and samples_per_block changes mid-transfer are ignored until the next IDLE.
//  - samples_per_block=0: step_q=0, all timestamps equal the start value. Legal, and verified.
//  Counters:
//  - cnt is 32-bit. every_q=1 alternates TS/DATA.
//  - inserted_count wraps 0xFFFFFFFF->0.
//  Timing:
//  - No combinational path m_axis_ready -> m_axis_valid.
//  - s_axis_ready depends combinationally on m_axis_ready only.
// STRUCTURE
//  - Shared package util_tx_timestamp_pkg:
//    - state enum {IDLE, HDR, TS, DATA, BYPASS}
//    - TS_WIDTH=64
//    - function blk_width(nch, spc, sdw)
//  - util_upack2_timestamp includes this package for TS_WIDTH.
//  - No sub-module. The step multiply is registered in IDLE, so one multiplier is inferred off the data path.
// TESTING
//  - every=4, spb=1, header 0x100, 8 data blocks D0..D7, ready=1 ->
//    out: TS 0x100, D0..D3, TS 0x104, D4..D7. inserted_count=2.
//  - every=3, spb=4, header 0xFFFF_FFFF_FFFF_FFF8 ->
//    timestamps ...FFF8, 0x4 (wrap), 0x10.
//  - every=0 -> header block forwarded as data, output stream == input stream, inserted_count unchanged.
//  - every=2; m_axis_ready toggles 1010...; random s_axis_valid ->
//    no beat lost or duplicated, data stable while stalled.
//  - xfer_req drops in DATA with a stalled beat; restart with header 0x500 ->
//    stalled beat dropped, first new output TS 0x500.
//  - dma_resetn=0 mid-DATA -> next cycle m_axis_valid=0, s_axis_ready=0, inserted_count=0.

Source files
------------

// File: rtl/util_tx_timestamp_pkg.sv
// Shared definitions for the TX timestamp framing path.
// Contents: timestamp width, inserter FSM state encodings, block-width helper.
package util_tx_timestamp_pkg;

  localparam int unsigned TS_WIDTH = 64;

  // Inserter FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR    = 3'd1;
  localparam logic [2:0] ST_TS     = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_BYPASS = 3'd4;

  // Bits per stream block
  function automatic int unsigned blk_width(input int unsigned nch,
                                            input int unsigned spc,
                                            input int unsigned sdw);
    return nch * spc * sdw;
  endfunction

endpackage

// File: rtl/util_tx_timestamp_inserter_if.sv
// DMA-style stream bundle: valid/ready handshake, transfer-active flag, data.
// master drives valid/xfer_req/data and samples ready; slave is the mirror.
interface util_tx_timestamp_inserter_if #(
  parameter int unsigned DW = 64
);

  logic          valid;
  logic          ready;
  logic          xfer_req;
  logic [DW-1:0] data;

  modport master (output valid, output xfer_req, output data, input ready);
  modport slave  (input valid, input xfer_req, input data, output ready);

endinterface

// File: rtl/util_tx_timestamp_inserter.sv
// Re-frames a TX DMA stream whose first block carries a 64-bit start timestamp
// into timestamp block + timestamp_every data blocks, repeated.
// Ports:
//   dma_clk, dma_resetn   clock, synchronous active-low reset
//   timestamp_every       data blocks per period (0 = bypass), sampled at transfer start
//   samples_per_block     per-channel samples per block, sampled at transfer start
//   inserted_count        timestamp blocks emitted since reset (wraps)
//   s_axis                DMA input stream (slave)
//   m_axis                output stream to util_upack2_timestamp (master)
module util_tx_timestamp_inserter
  import util_tx_timestamp_pkg::*;
#(
  parameter int unsigned NUM_OF_CHANNELS     = 4,
  parameter int unsigned SAMPLES_PER_CHANNEL = 1,
  parameter int unsigned SAMPLE_DATA_WIDTH   = 16
) (
  input  logic                          dma_clk,
  input  logic                          dma_resetn,
  input  logic [31:0]                   timestamp_every,
  input  logic [7:0]                    samples_per_block,
  output logic [31:0]                   inserted_count,
  util_tx_timestamp_inserter_if.slave   s_axis,
  util_tx_timestamp_inserter_if.master  m_axis
);

  localparam int unsigned DW = blk_width(NUM_OF_CHANNELS, SAMPLES_PER_CHANNEL, SAMPLE_DATA_WIDTH);

  if (DW < TS_WIDTH) begin : g_dw_check
    $error("util_tx_timestamp_inserter: block width %0d is narrower than the timestamp", DW);
  end

  logic [2:0]          state, state_nxt;
  logic [31:0]         every_q, cnt;
  logic [TS_WIDTH-1:0] step_q, ts_q;
  logic                m_valid, m_xfer_req;
  logic [DW-1:0]       m_data;
  logic                load_c, s_ready_c, s_hs_c, beat_c, last_c;

  assign load_c = !m_valid || m_axis.ready;
  assign s_hs_c = s_axis.valid && s_ready_c;
  assign last_c = (cnt == every_q - 32'd1);

  // Input accept: header sink in HDR, follows the output register in DATA/BYPASS
  always_comb begin
    s_ready_c = 1'b0;
    case (state)
      ST_HDR:             s_ready_c = 1'b1;
      ST_DATA, ST_BYPASS: s_ready_c = load_c;
      default:            s_ready_c = 1'b0;
    endcase
  end

  // Next state and output-register load strobe
  always_comb begin
    state_nxt = state;
    beat_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axis.xfer_req) state_nxt = (timestamp_every == 32'd0) ? ST_BYPASS : ST_HDR;
      end
      ST_HDR: begin
        if (s_hs_c) state_nxt = ST_TS;
      end
      ST_TS: begin
        beat_c = load_c;
        if (load_c) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        beat_c = s_hs_c;
        if (s_hs_c && last_c) state_nxt = ST_TS;
      end
      ST_BYPASS: begin
        beat_c = s_hs_c;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Transfer end or abort wins from any state
    if (!s_axis.xfer_req) state_nxt = ST_IDLE;
  end

  // State register
  always_ff @(posedge dma_clk) begin
    if (!dma_resetn) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Output register, timestamp accumulator and period counter
  always_ff @(posedge dma_clk) begin
    if (!dma_resetn) begin
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_xfer_req     <= 1'b0;
      inserted_count <= 32'd0;
      every_q        <= 32'd0;
      step_q         <= '0;
      ts_q           <= '0;
      cnt            <= 32'd0;
    end else begin
      m_xfer_req <= s_axis.xfer_req;

      // A beat still pending when the transfer ends is dropped
      if (!s_axis.xfer_req) begin
        m_valid <= 1'b0;
      end else if (beat_c) begin
        m_valid <= 1'b1;
        m_data  <= (state == ST_TS) ? DW'(ts_q) : s_axis.data;
      end else if (m_axis.ready) begin
        m_valid <= 1'b0;
      end

      // Configuration snapshot; the multiply stays off the data path
      if (state == ST_IDLE && s_axis.xfer_req) begin
        every_q <= timestamp_every;
        step_q  <= TS_WIDTH'(timestamp_every) * TS_WIDTH'(samples_per_block);
      end

      if (state == ST_HDR && s_hs_c && s_axis.xfer_req)
        ts_q <= s_axis.data[TS_WIDTH-1:0];

      if (state == ST_TS && load_c && s_axis.xfer_req) begin
        ts_q           <= ts_q + step_q;
        cnt            <= 32'd0;
        inserted_count <= inserted_count + 32'd1;
      end

      if (state == ST_DATA && s_hs_c && s_axis.xfer_req)
        cnt <= cnt + 32'd1;
    end
  end

  assign s_axis.ready    = s_ready_c;
  assign m_axis.valid    = m_valid;
  assign m_axis.data     = m_data;
  assign m_axis.xfer_req = m_xfer_req;

endmodule
